rock_ramp_seq: RTL
==================

# rock_ramp_seq

Rocking-motion sequencer between the baby-state controller and the cradle motor drive. Latches the controller's target amplitude/frequency, ramps the applied values one step per full rocking period, generates swing direction at the tick rate, and forces a controlled stop when disabled or when targets go stale.

## Interface

Parameters:

- HALF_UNIT, default 4: ticks per half-swing unit; half-swing length = (8 − freq) × HALF_UNIT ticks.
- TIMEOUT, default 200: ticks without `tgt_valid` before targets are treated as zero.

Ports:

- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: one-cycle slow-time enable; all timing advances only on `tick`.
- `enable`, in, 1: rocking permitted; low requests a ramp-down stop.
- `tgt_amp`, in, 3: target amplitude from the controller.
- `tgt_freq`, in, 3: target frequency from the controller.
- `tgt_valid`, in, 1: one-cycle strobe that latches `tgt_amp`/`tgt_freq`.
- `amp`, out, 3: applied amplitude.
- `freq`, out, 3: applied frequency.
- `dir`, out, 1: swing direction; 0 = left, 1 = right.
- `period_end`, out, 1: one-cycle pulse when a full period completes.
- `stale`, out, 1: watchdog expired.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- States: IDLE, SWING_L, SWING_R.
- Target register `t_amp`/`t_freq` loads on `tgt_valid`.
- Effective target is (0,0) when `enable` = 0, `stale` = 1, `t_amp` = 0 or `t_freq` = 0. Otherwise it is `t_amp`/`t_freq`.
- IDLE: `amp` = `freq` = 0 and `dir` = 0. On a `tick` with a nonzero effective target, go to SWING_L with `amp` = 1, `freq` = 1, and the half counter at 0.
- SWING_L/SWING_R: the half counter increments on each `tick`. On the tick where counter = half_len − 1, clear the counter and toggle state and `dir`.
  - half_len is computed from the currently applied `freq`.
- Full-period boundary is the last tick of SWING_R. At the boundary:
  - Pulse `period_end`.
  - If the effective target is nonzero, move `amp` and `freq` each ±1 toward the target; no step if already equal. `freq` never goes below 1 while swinging.
  - If the effective target is zero, decrement `amp` by 1 and hold `freq`. When `amp` reaches 0, set `freq` to 0, clear `dir`, and go to IDLE instead of SWING_L.
- Watchdog counts ticks and saturates at TIMEOUT. `tgt_valid` clears both the count and `stale`. `stale` asserts on the tick the count reaches TIMEOUT.
- Arithmetic: `amp`/`freq` are unsigned 3-bit and are never stepped outside 0..7. The half counter width is clog2(7 × HALF_UNIT). The watchdog width is clog2(TIMEOUT + 1).

## Timing

- All outputs are registered. Reset value of every output and internal register is 0.
- `tick` low: no state, counter or output changes, except that `tgt_valid` still latches targets and clears the watchdog.
- Target latency: a latched target affects `amp`/`freq` at the next period boundary, or the next tick when in IDLE.
- `tgt_valid` in the same cycle as a boundary: the boundary uses the old `t_amp`/`t_freq`; the new value takes effect at the following boundary.
- `enable` drop mid-swing: the current period completes, then ramp-down starts. Motion is never truncated mid-swing.
- `reset` mid-swing: all registers and outputs are 0 at the next edge, regardless of `tick`.
- `period_end` is high exactly one clk cycle, coincident with the boundary tick.

## Structure

- Shared package `rock_pkg`:
  - `AMP_W` = 3, `FREQ_W` = 3.
  - State enum `rock_state_t` (IDLE, SWING_L, SWING_R).
  - Helper function `half_len(freq, unit)`.
- Sub-module `rock_watchdog`: tick counter with saturation; outputs `stale`.
- Main FSM and ramp logic live in `rock_ramp_seq`.

## Test plan

All scenarios use HALF_UNIT = 2 and TIMEOUT = 100.

- **Start-up ramp.** Reset, `enable` = 1, `tgt_valid` with amp = 3, freq = 2, continuous `tick`.
  - Next tick: `amp` = 1, `freq` = 1, `dir` = 0.
  - `dir` toggles after 14 ticks.
  - `period_end` at tick 28, giving `amp` = 2, `freq` = 2.
  - Next half-swing is 12 ticks; the next boundary gives `amp` = 3, `freq` = 2.
- **Enable drop.** At `amp` = 3, `freq` = 2, drop `enable` mid SWING_L.
  - The period completes, then `amp` steps 2, 1, 0 over three boundaries.
  - At the last boundary `freq` = 0 and the block goes to IDLE with `busy` = 0.
- **Watchdog.** No `tgt_valid` for 100 ticks.
  - `stale` = 1 and ramp-down begins at the next boundary.
  - A later `tgt_valid` clears `stale`, and the ramp-up resumes.
- **Boundary collision.** `tgt_valid` (amp = 1) in the same cycle as the boundary tick while `amp` = 2, target 3.
  - That boundary steps `amp` to 3.
  - The next boundary steps it to 2.
- **Reset mid-swing / tick gating.**
  - Assert `reset` with `tick` = 0: all outputs are 0 the next cycle.
  - Holding `tick` low for 50 cycles while swinging changes no counters or outputs.

Source files
------------

// File: rtl/rock_pkg.sv
// Shared types and helpers for the rocking-motion sequencer.
// Widths, FSM state encoding and swing-length arithmetic.
package rock_pkg;

  localparam int AMP_W  = 3;
  localparam int FREQ_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWING_L = 2'd1,
    SWING_R = 2'd2
  } rock_state_t;

  // Ticks in one half-swing at a given applied frequency.
  function automatic int unsigned half_len(
    input logic [FREQ_W-1:0] freq,
    input int unsigned       unit
  );
    return (32'd8 - 32'(freq)) * unit;
  endfunction

endpackage

// File: rtl/rock_watchdog.sv
// Target-freshness watchdog: counts ticks since the last
// target strobe, saturating, and flags stale targets.
import rock_pkg::*;

module rock_watchdog #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic stale
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;
  logic         stale_q, stale_d;

  // Count ticks up to the limit; a strobe restarts the window.
  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (clear) begin
      cnt_d   = '0;
      stale_d = 1'b0;
    end else if (tick) begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + W'(1);
      if (cnt_d == LIMIT) stale_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;

endmodule

// File: rtl/rock_ramp_seq.sv
// Rocking sequencer: latches targets, swings left/right on
// ticks and ramps amp/freq one step per full period.
import rock_pkg::*;

module rock_ramp_seq #(
  parameter int unsigned HALF_UNIT = 4,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic [2:0] tgt_amp,
  input  logic [2:0] tgt_freq,
  input  logic       tgt_valid,
  output logic [2:0] amp,
  output logic [2:0] freq,
  output logic       dir,
  output logic       period_end,
  output logic       stale,
  output logic       busy
);

  localparam int CNT_W = $clog2(7 * HALF_UNIT);

  rock_state_t state_q, state_d;

  logic [AMP_W-1:0]  amp_q, amp_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [AMP_W-1:0]  t_amp_q, t_amp_d;
  logic [FREQ_W-1:0] t_freq_q, t_freq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              pe_q, pe_d;
  logic              busy_q, busy_d;

  logic              stale_w;
  logic              eff_nz;
  logic [CNT_W-1:0]  last_cnt;

  function automatic logic [2:0] step_to(
    input logic [2:0] cur,
    input logic [2:0] tgt
  );
    if (cur < tgt) return cur + 3'd1;
    if (cur > tgt) return cur - 3'd1;
    return cur;
  endfunction

  rock_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .clear (tgt_valid),
    .stale (stale_w)
  );

  assign eff_nz = enable & ~stale_w
                & (t_amp_q != '0) & (t_freq_q != '0);

  assign last_cnt =
    CNT_W'(half_len(freq_q, HALF_UNIT) - 32'd1);

  // Next state: swing timing, boundary ramp and stop.
  always_comb begin
    state_d  = state_q;
    amp_d    = amp_q;
    freq_d   = freq_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    pe_d     = 1'b0;
    t_amp_d  = tgt_valid ? tgt_amp  : t_amp_q;
    t_freq_d = tgt_valid ? tgt_freq : t_freq_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (eff_nz) begin
            state_d = SWING_L;
            amp_d   = 3'd1;
            freq_d  = 3'd1;
            cnt_d   = '0;
            dir_d   = 1'b0;
          end
        end
        SWING_L: begin
          if (cnt_q == last_cnt) begin
            cnt_d   = '0;
            state_d = SWING_R;
            dir_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SWING_R: begin
          if (cnt_q == last_cnt) begin
            cnt_d   = '0;
            dir_d   = 1'b0;
            pe_d    = 1'b1;
            state_d = SWING_L;
            if (eff_nz) begin
              amp_d  = step_to(amp_q, t_amp_q);
              freq_d = step_to(freq_q, t_freq_q);
            end else if (amp_q <= 3'd1) begin
              amp_d   = '0;
              freq_d  = '0;
              state_d = IDLE;
            end else begin
              amp_d = amp_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, applied values and latched targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      amp_q    <= '0;
      freq_q   <= '0;
      t_amp_q  <= '0;
      t_freq_q <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      pe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      freq_q   <= freq_d;
      t_amp_q  <= t_amp_d;
      t_freq_q <= t_freq_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      pe_q     <= pe_d;
      busy_q   <= busy_d;
    end
  end

  assign amp        = amp_q;
  assign freq       = freq_q;
  assign dir        = dir_q;
  assign period_end = pe_q;
  assign stale      = stale_w;
  assign busy       = busy_q;

endmodule
